// File: rtl/int_responder_pkg.sv
// -----------------------------------------------------------------------------
// int_responder_pkg
// Shared definitions for the interrupt responder: responder state encoding,
// controller register-select encodings, the controller data-bus width and a
// helper that sizes the holdoff down-counter.
// -----------------------------------------------------------------------------
package int_responder_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      ACK,
      CAPTURE,
      DISPATCH,
      SERVICE,
      HOLDOFF,
      RD_DRIVE,
      RD_CAPTURE
   } state_t;

   // Controller register-select encodings driven on s
   localparam logic [1:0] SEL_0 = 2'b00;
   localparam logic [1:0] SEL_1 = 2'b01;
   localparam logic [1:0] SEL_2 = 2'b10;
   localparam logic [1:0] SEL_3 = 2'b11;

   // Value of s whenever no register read is in progress
   localparam logic [1:0] SEL_NONE = SEL_0;

   // Counter width able to hold (cycles - 1); never narrower than one bit
   function automatic int timer_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/holdoff_timer.sv
// -----------------------------------------------------------------------------
// holdoff_timer
// Down-counter that paces the post-service holdoff window.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, clears the count
//   load   : load LOAD_VAL (takes priority over count)
//   count  : decrement by one while non-zero
//   zero   : count has reached zero
// -----------------------------------------------------------------------------
module holdoff_timer
   import int_responder_pkg::*;
#(
   parameter int             W        = 1,
   parameter logic [W-1:0]   LOAD_VAL = '0
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic count,
   output logic zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/int_responder.sv
// -----------------------------------------------------------------------------
// int_responder
// Core-side interrupt responder. Accepts an interrupt from the interrupt
// controller, acknowledges it, captures the vector, hands it to the core,
// waits for the service routine to finish and then holds off new interrupts
// for HOLDOFF_CYCLES cycles. In idle it can also perform a controller
// register read on behalf of the core.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   int_req / int_ack   : request from / one-cycle acknowledge to controller
//   data_bus            : vector or register data from controller
//   read / s            : register-read enable and register select
//   int_en              : core-side global interrupt enable (gates IDLE only)
//   vec / vec_valid     : captured vector, held until vec_ready
//   vec_ready           : core accepts the vector
//   isr_done            : core finished the service routine (pulse)
//   rd_req / rd_sel     : core register-read request and select
//   rd_data / rd_valid  : read result and its one-cycle strobe
//   busy                : responder is not idle
//   served_cnt          : saturating count of completed services
// -----------------------------------------------------------------------------
module int_responder
   import int_responder_pkg::*;
#(
   parameter int HOLDOFF_CYCLES = 2,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              int_req,
   output logic              int_ack,
   input  logic [DATA_W-1:0] data_bus,
   output logic              read,
   output logic [1:0]        s,
   input  logic              int_en,
   output logic [DATA_W-1:0] vec,
   output logic              vec_valid,
   input  logic              vec_ready,
   input  logic              isr_done,
   input  logic              rd_req,
   input  logic [1:0]        rd_sel,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic [CNT_W-1:0]  served_cnt
);

   localparam int           HW        = timer_width(HOLDOFF_CYCLES);
   // Timer is loaded with N-1 so that HOLDOFF is occupied for exactly N cycles
   localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HW'(HOLDOFF_CYCLES - 1) : '0;

   state_t              state;
   state_t              next;
   logic [1:0]          sel_q;
   logic [DATA_W-1:0]   vec_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic [CNT_W-1:0]    served_q;
   logic                hold_load;
   logic                hold_count;
   logic                hold_zero;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   holdoff_timer #(
      .W        (HW),
      .LOAD_VAL (HOLD_LOAD)
   ) u_holdoff (
      .clk   (clk),
      .reset (reset),
      .load  (hold_load),
      .count (hold_count),
      .zero  (hold_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         sel_q     <= SEL_NONE;
         vec_q     <= '0;
         rd_data_q <= '0;
         served_q  <= '0;
      end else begin
         state <= next;
         if ((state == IDLE) && (next == RD_DRIVE)) begin
            sel_q <= rd_sel;
         end
         if (state == CAPTURE) begin
            vec_q <= data_bus;
         end
         if (state == RD_CAPTURE) begin
            rd_data_q <= data_bus;
         end
         if ((state == SERVICE) && isr_done) begin
            served_q <= sat_inc(served_q);
         end
      end
   end

   always_comb begin
      next       = state;
      hold_load  = 1'b0;
      hold_count = 1'b0;
      int_ack    = 1'b0;
      read       = 1'b0;
      s          = SEL_NONE;
      vec_valid  = 1'b0;
      rd_valid   = 1'b0;
      // Registered value outside RD_CAPTURE; during RD_CAPTURE the bus is
      // passed straight through so rd_valid and the new value coincide.
      rd_data    = rd_data_q;

      unique case (state)
         IDLE: begin
            if (int_req && int_en) begin
               next = ACK;
            end else if (rd_req) begin
               next = RD_DRIVE;
            end
         end
         ACK: begin
            int_ack = 1'b1;
            next    = CAPTURE;
         end
         CAPTURE: begin
            next = DISPATCH;
         end
         DISPATCH: begin
            vec_valid = 1'b1;
            if (vec_ready) begin
               next = SERVICE;
            end
         end
         SERVICE: begin
            if (isr_done) begin
               if (HOLDOFF_CYCLES == 0) begin
                  next = IDLE;
               end else begin
                  next      = HOLDOFF;
                  hold_load = 1'b1;
               end
            end
         end
         HOLDOFF: begin
            hold_count = 1'b1;
            if (hold_zero) begin
               next = IDLE;
            end
         end
         RD_DRIVE: begin
            read = 1'b1;
            s    = sel_q;
            next = RD_CAPTURE;
         end
         RD_CAPTURE: begin
            read     = 1'b1;
            s        = sel_q;
            rd_valid = 1'b1;
            rd_data  = data_bus;
            next     = IDLE;
         end
         default: begin
            next = IDLE;
         end
      endcase
   end

   assign vec        = vec_q;
   assign busy       = (state != IDLE);
   assign served_cnt = served_q;

endmodule

// File: tb/tb_int_responder.sv
module tb_int_responder;
   import int_responder_pkg::*;

   localparam int HOLD = 2;
   localparam int CW   = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              int_req;
   logic              int_ack;
   logic [31:0]       data_bus;
   logic              read;
   logic [1:0]        s;
   logic              int_en;
   logic [31:0]       vec;
   logic              vec_valid;
   logic              vec_ready;
   logic              isr_done;
   logic              rd_req;
   logic [1:0]        rd_sel;
   logic [31:0]       rd_data;
   logic              rd_valid;
   logic              busy;
   logic [CW-1:0]     served_cnt;

   int                checks   = 0;
   int                failures = 0;
   logic [31:0]       vec_q[$];
   logic [31:0]       rd_q[$];
   logic [CW-1:0]     exp_cnt;
   logic              vv_prev;

   int_responder #(
      .HOLDOFF_CYCLES (HOLD),
      .CNT_W          (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .int_req    (int_req),
      .int_ack    (int_ack),
      .data_bus   (data_bus),
      .read       (read),
      .s          (s),
      .int_en     (int_en),
      .vec        (vec),
      .vec_valid  (vec_valid),
      .vec_ready  (vec_ready),
      .isr_done   (isr_done),
      .rd_req     (rd_req),
      .rd_sel     (rd_sel),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .served_cnt (served_cnt)
   );

   always #5 clk = ~clk;

   // Advance one cycle; outputs are then sampled and inputs driven at negedge
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1; int_req = 1'b0; int_en = 1'b0; vec_ready = 1'b0;
      isr_done = 1'b0; rd_req = 1'b0; rd_sel = 2'b00; data_bus = 32'h0;
      tick; tick;
      checks++;
      if ({int_ack, read, s, vec_valid, rd_valid, busy} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=%b", {int_ack, read, s, vec_valid, rd_valid, busy}, 7'b0);
      end
      checks++;
      if (vec !== 32'h0) begin failures++; $display("FAIL reset_vec got=%h exp=%h", vec, 32'h0); end
      checks++;
      if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data, 32'h0); end
      checks++;
      if (served_cnt !== '0) begin failures++; $display("FAIL reset_served got=%0d exp=0", served_cnt); end
      exp_cnt = '0;
      reset = 1'b0;
      tick;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
   endtask

   task automatic test_interrupt;
      logic [2:0]  tab [1:10];
      logic [31:0] exp_v;
      // {int_ack, vec_valid, busy}
      tab = '{3'b101, 3'b001, 3'b011, 3'b011, 3'b011, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
      int_en = 1'b1; int_req = 1'b1; data_bus = 32'h0000_001F;
      vec_q.push_back(32'h0000_001F);
      vv_prev = vec_valid;
      for (int c = 1; c <= 10; c++) begin
         tick;
         checks++;
         if ({int_ack, vec_valid, busy} !== tab[c]) begin
            failures++;
            $display("FAIL irq_cycle%0d got=%b exp=%b", c, {int_ack, vec_valid, busy}, tab[c]);
         end
         if (vec_valid && !vv_prev) begin
            checks++;
            if (vec_q.size() == 0) begin
               failures++; $display("FAIL irq_vec_extra got=%h exp=none", vec);
            end else begin
               exp_v = vec_q.pop_front();
               if (vec !== exp_v) begin failures++; $display("FAIL irq_vec got=%h exp=%h", vec, exp_v); end
            end
         end
         vv_prev = vec_valid;
         if (c == 5) begin
            checks++;
            if (vec !== 32'h0000_001F) begin failures++; $display("FAIL irq_vec_stable got=%h exp=%h", vec, 32'h1F); end
         end
         if (c == 6) begin
            checks++;
            if (served_cnt !== exp_cnt) begin failures++; $display("FAIL irq_early_isr got=%0d exp=%0d", served_cnt, exp_cnt); end
         end
         if (c == 8) begin
            exp_cnt = (exp_cnt == '1) ? exp_cnt : exp_cnt + 1'b1;
            checks++;
            if (served_cnt !== exp_cnt) begin failures++; $display("FAIL irq_served got=%0d exp=%0d", served_cnt, exp_cnt); end
         end
         case (c)
            1: begin int_req = 1'b0; int_en = 1'b0; vec_ready = 1'b1; end
            3: begin data_bus = 32'hDEAD_BEEF; vec_ready = 1'b0; isr_done = 1'b1; end
            4: isr_done = 1'b0;
            5: begin vec_ready = 1'b1; isr_done = 1'b1; end
            6: begin vec_ready = 1'b0; isr_done = 1'b0; end
            7: isr_done = 1'b1;
            8: isr_done = 1'b0;
            default: ;
         endcase
      end
   endtask

   task automatic test_read;
      logic [4:0]  tab [1:4];
      logic [31:0] exp_r;
      // {read, s, rd_valid, busy}
      tab = '{5'b1_01_0_1, 5'b1_01_1_1, 5'b0_00_0_0, 5'b0_00_0_0};
      rd_req = 1'b1; rd_sel = 2'b01; data_bus = 32'hFFFF_FFF7;
      rd_q.push_back(32'hFFFF_FFF7);
      for (int c = 1; c <= 4; c++) begin
         tick;
         checks++;
         if ({read, s, rd_valid, busy} !== tab[c]) begin
            failures++;
            $display("FAIL read_cycle%0d got=%b exp=%b", c, {read, s, rd_valid, busy}, tab[c]);
         end
         if (rd_valid) begin
            checks++;
            if (rd_q.size() == 0) begin
               failures++; $display("FAIL read_extra got=%h exp=none", rd_data);
            end else begin
               exp_r = rd_q.pop_front();
               if (rd_data !== exp_r) begin failures++; $display("FAIL read_data got=%h exp=%h", rd_data, exp_r); end
            end
         end
         if (c == 4) begin
            checks++;
            if (rd_data !== 32'hFFFF_FFF7) begin failures++; $display("FAIL read_hold got=%h exp=%h", rd_data, 32'hFFFF_FFF7); end
         end
         case (c)
            1: begin rd_req = 1'b0; rd_sel = 2'b11; end
            3: data_bus = 32'h1234_5678;
            default: ;
         endcase
      end
      checks++;
      if (rd_q.size() != 0) begin failures++; $display("FAIL read_missing got=%0d exp=0", rd_q.size()); rd_q.delete(); end
   endtask

   task automatic test_priority;
      logic [4:0]  tab [1:10];
      logic [31:0] exp_v;
      // {int_ack, read, s, busy}
      tab = '{5'b1_0_00_1, 5'b0_0_00_1, 5'b0_0_00_1, 5'b0_0_00_1, 5'b0_0_00_1,
              5'b0_0_00_1, 5'b0_0_00_0, 5'b0_1_10_1, 5'b0_1_10_1, 5'b0_0_00_0};
      int_en = 1'b1; int_req = 1'b1; rd_req = 1'b1; rd_sel = 2'b10; data_bus = 32'h0000_0055;
      vec_q.push_back(32'h0000_0055);
      vv_prev = vec_valid;
      for (int c = 1; c <= 10; c++) begin
         tick;
         checks++;
         if ({int_ack, read, s, busy} !== tab[c]) begin
            failures++;
            $display("FAIL prio_cycle%0d got=%b exp=%b", c, {int_ack, read, s, busy}, tab[c]);
         end
         if (vec_valid && !vv_prev) begin
            checks++;
            if (vec_q.size() == 0) begin
               failures++; $display("FAIL prio_vec_extra got=%h exp=none", vec);
            end else begin
               exp_v = vec_q.pop_front();
               if (vec !== exp_v) begin failures++; $display("FAIL prio_vec got=%h exp=%h", vec, exp_v); end
            end
         end
         vv_prev = vec_valid;
         if (rd_valid) begin
            checks++;
            if (rd_q.size() == 0) begin
               failures++; $display("FAIL prio_rd_extra got=%h exp=none", rd_data);
            end else begin
               exp_v = rd_q.pop_front();
               if (rd_data !== exp_v) begin failures++; $display("FAIL prio_rd_data got=%h exp=%h", rd_data, exp_v); end
            end
         end
         if (c == 6) begin
            exp_cnt = (exp_cnt == '1) ? exp_cnt : exp_cnt + 1'b1;
            checks++;
            if (served_cnt !== exp_cnt) begin failures++; $display("FAIL prio_served got=%0d exp=%0d", served_cnt, exp_cnt); end
         end
         case (c)
            1: int_req = 1'b0;
            3: vec_ready = 1'b1;
            4: begin vec_ready = 1'b0; isr_done = 1'b1; end
            5: isr_done = 1'b0;
            7: begin data_bus = 32'hA5A5_0001; rd_q.push_back(32'hA5A5_0001); end
            8: rd_req = 1'b0;
            default: ;
         endcase
      end
   endtask

   task automatic test_gating;
      logic [1:0]  tab [1:14];
      logic [31:0] exp_v;
      int_en = 1'b0; int_req = 1'b1; data_bus = 32'h0000_0A0A;
      for (int c = 1; c <= 20; c++) begin
         tick;
         checks++;
         if ({int_ack, busy} !== 2'b00) begin
            failures++; $display("FAIL gate_cycle%0d got=%b exp=%b", c, {int_ack, busy}, 2'b00);
         end
      end
      // {int_ack, busy}; int_req stays high through the holdoff window
      tab = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
              2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
      int_en = 1'b1;
      vec_q.push_back(32'h0000_0A0A);
      vv_prev = vec_valid;
      for (int c = 1; c <= 14; c++) begin
         tick;
         checks++;
         if ({int_ack, busy} !== tab[c]) begin
            failures++; $display("FAIL hold_cycle%0d got=%b exp=%b", c, {int_ack, busy}, tab[c]);
         end
         if (vec_valid && !vv_prev) begin
            checks++;
            if (vec_q.size() == 0) begin
               failures++; $display("FAIL hold_vec_extra got=%h exp=none", vec);
            end else begin
               exp_v = vec_q.pop_front();
               if (vec !== exp_v) begin failures++; $display("FAIL hold_vec got=%h exp=%h", vec, exp_v); end
            end
         end
         vv_prev = vec_valid;
         if (c == 5 || c == 12) begin
            exp_cnt = (exp_cnt == '1) ? exp_cnt : exp_cnt + 1'b1;
            checks++;
            if (served_cnt !== exp_cnt) begin failures++; $display("FAIL hold_served got=%0d exp=%0d", served_cnt, exp_cnt); end
         end
         case (c)
            3:  begin vec_ready = 1'b1; data_bus = 32'h0000_0B0B; vec_q.push_back(32'h0000_0B0B); end
            4:  begin vec_ready = 1'b0; isr_done = 1'b1; end
            5:  isr_done = 1'b0;
            8:  int_req = 1'b0;
            10: vec_ready = 1'b1;
            11: begin vec_ready = 1'b0; isr_done = 1'b1; end
            12: isr_done = 1'b0;
            default: ;
         endcase
      end
   endtask

   task automatic test_reset_dispatch;
      logic [31:0] exp_v;
      int_en = 1'b1; int_req = 1'b1; data_bus = 32'h0000_0077;
      vec_q.push_back(32'h0000_0077);
      vv_prev = vec_valid;
      for (int c = 1; c <= 3; c++) begin
         tick;
         if (vec_valid && !vv_prev) begin
            checks++;
            if (vec_q.size() == 0) begin
               failures++; $display("FAIL rst_vec_extra got=%h exp=none", vec);
            end else begin
               exp_v = vec_q.pop_front();
               if (vec !== exp_v) begin failures++; $display("FAIL rst_vec got=%h exp=%h", vec, exp_v); end
            end
         end
         vv_prev = vec_valid;
         if (c == 1) int_req = 1'b0;
      end
      checks++;
      if (vec_valid !== 1'b1) begin failures++; $display("FAIL rst_in_dispatch got=%b exp=1", vec_valid); end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      exp_cnt = '0;
      checks++;
      if ({vec_valid, busy, int_ack} !== 3'b000) begin
         failures++; $display("FAIL rst_disp_ctrl got=%b exp=%b", {vec_valid, busy, int_ack}, 3'b000);
      end
      checks++;
      if (served_cnt !== exp_cnt) begin failures++; $display("FAIL rst_disp_served got=%0d exp=%0d", served_cnt, exp_cnt); end
      checks++;
      if (vec !== 32'h0) begin failures++; $display("FAIL rst_disp_vec got=%h exp=%h", vec, 32'h0); end

      int_req = 1'b1;
      tick;
      checks++;
      if (int_ack !== 1'b1) begin failures++; $display("FAIL rst_ack_pre got=%b exp=1", int_ack); end
      reset = 1'b1; int_req = 1'b0;
      tick;
      reset = 1'b0;
      checks++;
      if ({int_ack, busy} !== 2'b00) begin failures++; $display("FAIL rst_ack_post got=%b exp=%b", {int_ack, busy}, 2'b00); end

      rd_req = 1'b1; rd_sel = 2'b11; data_bus = 32'h0BAD_0BAD;
      tick;
      checks++;
      if ({read, s} !== 3'b111) begin failures++; $display("FAIL rst_rd_pre got=%b exp=%b", {read, s}, 3'b111); end
      reset = 1'b1; rd_req = 1'b0;
      tick;
      reset = 1'b0;
      checks++;
      if ({read, s, rd_valid, busy} !== 5'b0) begin
         failures++; $display("FAIL rst_rd_post got=%b exp=%b", {read, s, rd_valid, busy}, 5'b0);
      end
      checks++;
      if (rd_data !== 32'h0) begin failures++; $display("FAIL rst_rd_data got=%h exp=%h", rd_data, 32'h0); end
      tick;
   endtask

   task automatic test_saturation;
      logic [31:0] exp_v;
      int          n;
      for (int k = 0; k < 5; k++) begin
         int_en = 1'b1; int_req = 1'b1; data_bus = 32'h0000_0100 + k;
         vec_q.push_back(32'h0000_0100 + k);
         tick;
         int_req = 1'b0;
         n = 0;
         while (!vec_valid && n < 20) begin tick; n++; end
         checks++;
         if (!vec_valid) begin
            failures++; $display("FAIL sat_vec_timeout got=%b exp=1", vec_valid);
            vec_q.delete();
         end else begin
            exp_v = vec_q.pop_front();
            if (vec !== exp_v) begin failures++; $display("FAIL sat_vec got=%h exp=%h", vec, exp_v); end
         end
         vec_ready = 1'b1;
         tick;
         vec_ready = 1'b0;
         isr_done = 1'b1;
         tick;
         isr_done = 1'b0;
         exp_cnt = (exp_cnt == '1) ? exp_cnt : exp_cnt + 1'b1;
         checks++;
         if (served_cnt !== exp_cnt) begin failures++; $display("FAIL sat_served%0d got=%0d exp=%0d", k, served_cnt, exp_cnt); end
         n = 0;
         while (busy && n < 20) begin tick; n++; end
         checks++;
         if (busy) begin failures++; $display("FAIL sat_idle_timeout got=%b exp=0", busy); end
      end
      checks++;
      if (served_cnt !== 2'b11) begin failures++; $display("FAIL sat_final got=%0d exp=3", served_cnt); end
   endtask

   initial begin
      test_reset;
      test_interrupt;
      test_read;
      test_priority;
      test_gating;
      test_reset_dispatch;
      test_saturation;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
